// File: rtl/dvp_axi_pkg.sv
// ============================================================================
//  Module   : dvp_axi_pkg
//  Purpose  : Shared AXI write-initiator constants and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dvp_axi_pkg;

  // Burst FSM states; the encoding width is fixed so the state register is 3 bits.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } state_t;

  // Every beat writes all four byte lanes.
  localparam logic [3:0] AXI_WSTRB_ALL = 4'hF;

  // Address advance per 32-bit beat.
  localparam int AXI_BYTES_PER_BEAT = 4;

endpackage

`default_nettype wire

// File: rtl/dvp_sync_fifo.sv
// ============================================================================
//  Module   : dvp_sync_fifo
//  Purpose  : Single-clock show-ahead FIFO with occupancy count.
//             The head word is visible on 'head' whenever the FIFO is non-empty.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dvp_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == (c_ptr_w + 1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_burst_wr.sv
// ============================================================================
//  Module   : axi_burst_wr
//  Purpose  : AXI write initiator. Buffers a 32-bit word stream and writes a
//             job of total_words words from base_addr upward as INCR bursts.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_burst_wr #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [23:0] total_words,
  output logic        busy,
  output logic        done,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] axi_awaddr,
  output logic [7:0]  axi_awlen,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  output logic        axi_wlast,
  input  logic        axi_bvalid,
  output logic        axi_bready
);

  import dvp_axi_pkg::*;

  localparam int         c_cnt_w       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0] c_burst_beats = 9'(BURST_LEN);

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_addr;
  logic [23:0]         r_remaining;
  logic [23:0]         r_total;
  logic [23:0]         r_accepted;
  logic [8:0]          r_beats;
  logic [8:0]          r_beat_cnt;
  logic [31:0]         r_awaddr;
  logic [7:0]          r_awlen;
  logic                r_done;

  logic [8:0]          w_beats;
  logic                w_burst_ready;
  logic                w_last_burst;
  logic                w_push;
  logic                w_pop;
  logic [31:0]         w_head;
  logic [c_cnt_w-1:0]  w_count;
  logic                w_full;
  logic                w_empty;

  dvp_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (axi_aclk),
    .rstn      (axi_aresetn),
    .push      (w_push),
    .push_data (in_data),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Size of the next burst and whether enough words are buffered to issue it
  // without ever running the FIFO dry during W.
  always_comb begin
    w_beats       = (r_remaining >= 24'(BURST_LEN)) ? c_burst_beats : r_remaining[8:0];
    w_burst_ready = (32'(w_count) >= 32'(w_beats));
    w_last_burst  = (r_remaining == {15'd0, r_beats});
  end

  // Handshake-facing outputs are decoded from the registered state so they
  // change only on clock edges and hold steady while the slave stalls.
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign in_ready    = busy & ~w_full & (r_accepted < r_total);
  assign axi_awvalid = (r_state == ST_AW);
  assign axi_awaddr  = r_awaddr;
  assign axi_awlen   = r_awlen;
  assign axi_wvalid  = (r_state == ST_W);
  assign axi_wdata   = (axi_wvalid && !w_empty) ? w_head : 32'd0;
  assign axi_wstrb   = AXI_WSTRB_ALL;
  assign axi_wlast   = axi_wvalid && (r_beat_cnt == (r_beats - 9'd1));
  assign axi_bready  = (r_state == ST_B);
  assign w_push      = in_valid & in_ready;
  assign w_pop       = axi_wvalid & axi_wready;

  // State register.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) r_state <= ST_IDLE;
    else              r_state <= w_next;
  end

  // Next-state decode: one AW, then the data beats, then the response per burst.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start && (total_words != 24'd0)) w_next = ST_WAIT;
      ST_WAIT: if (w_burst_ready)                   w_next = ST_AW;
      ST_AW:   if (axi_awready)                     w_next = ST_W;
      ST_W:    if (axi_wready && axi_wlast)         w_next = ST_B;
      ST_B:    if (axi_bvalid)                      w_next = w_last_burst ? ST_IDLE : ST_WAIT;
      default:                                      w_next = ST_IDLE;
    endcase
  end

  // Job counters, burst address/length registers and the done pulse.
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_addr      <= 32'd0;
      r_remaining <= 24'd0;
      r_total     <= 24'd0;
      r_accepted  <= 24'd0;
      r_beats     <= 9'd0;
      r_beat_cnt  <= 9'd0;
      r_awaddr    <= 32'd0;
      r_awlen     <= 8'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_accepted <= r_accepted + 24'd1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (total_words != 24'd0) begin
              r_addr      <= base_addr;
              r_remaining <= total_words;
              r_total     <= total_words;
              r_accepted  <= 24'd0;
            end else begin
              // Empty job completes immediately without touching the bus.
              r_done <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (w_burst_ready) begin
            r_awaddr   <= r_addr;
            r_awlen    <= 8'(w_beats - 9'd1);
            r_beats    <= w_beats;
            r_beat_cnt <= 9'd0;
          end
        end
        ST_W: begin
          if (w_pop) r_beat_cnt <= r_beat_cnt + 9'd1;
        end
        ST_B: begin
          if (axi_bvalid) begin
            r_addr      <= r_addr + (32'(r_beats) * 32'(AXI_BYTES_PER_BEAT));
            r_remaining <= r_remaining - {15'd0, r_beats};
            if (w_last_burst) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_burst_wr.sv
// ============================================================================
//  Module   : tb_axi_burst_wr
//  Purpose  : Scoreboard bench for axi_burst_wr with a small AXI slave and
//             stream source.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_burst_wr;

  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'd0;
  logic [23:0] total_words = 24'd0;
  logic        busy, done;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic        axi_awvalid;
  logic        axi_awready = 1'b0;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready = 1'b0;
  logic        axi_wlast;
  logic        axi_bvalid = 1'b0;
  logic        axi_bready;

  always #5 clk = ~clk;

  axi_burst_wr #(.BURST_LEN(BL), .FIFO_DEPTH(64)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .start(start), .base_addr(base_addr),
    .total_words(total_words), .busy(busy), .done(done), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid),
    .axi_bready(axi_bready)
  );

  // Scoreboard: expected AW {len, addr} and W {last, data} per issued job.
  logic [39:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];

  int nvec = 0, nerr = 0;
  logic [31:0] word_ctr = 32'd0;
  int acc_cnt = 0, done_cnt = 0, w_hs_cnt = 0, aw_open = 0;
  int pending_b = 0, bwait = 0, aw_wait = 0, cyc = 0;
  int smode = 0, awmode = 0, wmode = 0, bdelay = 0;
  logic hs_in = 0, hs_aw = 0, hs_w = 0, hs_wlast = 0, hs_b = 0;
  logic rst_edge = 1'b1;
  logic prev_aw_stall = 0, prev_w_stall = 0, prev_wlast = 0;
  logic [31:0] prev_awaddr = 0, prev_wdata = 0;
  logic [7:0]  prev_awlen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_edge = !rstn;

  // Monitor: sample away from the edge, pop expectations on each handshake.
  always @(negedge clk) begin
    if (!rstn || rst_edge) begin
      hs_in = 0; hs_aw = 0; hs_w = 0; hs_wlast = 0; hs_b = 0;
      prev_aw_stall = 0; prev_w_stall = 0; aw_open = 0;
    end else begin
      hs_in    = in_valid && in_ready;
      hs_aw    = axi_awvalid && axi_awready;
      hs_w     = axi_wvalid && axi_wready;
      hs_wlast = hs_w && axi_wlast;
      hs_b     = axi_bvalid && axi_bready;
      if (hs_in) acc_cnt++;
      if (prev_aw_stall)
        chk("aw_hold", 64'({axi_awvalid, axi_awlen, axi_awaddr}), 64'({1'b1, prev_awlen, prev_awaddr}));
      if (prev_w_stall)
        chk("w_hold", 64'({axi_wvalid, axi_wlast, axi_wdata}), 64'({1'b1, prev_wlast, prev_wdata}));
      if (axi_wvalid) chk("w_after_aw", 64'(aw_open > 0), 64'(1));
      if (hs_aw) begin
        chk("aw_expected", 64'(exp_aw_q.size() > 0), 64'(1));
        if (exp_aw_q.size() > 0) begin
          logic [39:0] e;
          e = exp_aw_q.pop_front();
          chk("awaddr", 64'(axi_awaddr), 64'(e[31:0]));
          chk("awlen", 64'(axi_awlen), 64'(e[39:32]));
        end
        aw_open += int'(axi_awlen) + 1;
      end
      if (hs_w) begin
        w_hs_cnt++;
        aw_open--;
        chk("wstrb", 64'(axi_wstrb), 64'(4'hF));
        chk("w_expected", 64'(exp_w_q.size() > 0), 64'(1));
        if (exp_w_q.size() > 0) begin
          logic [32:0] e;
          e = exp_w_q.pop_front();
          chk("wdata", 64'(axi_wdata), 64'(e[31:0]));
          chk("wlast", 64'(axi_wlast), 64'(e[32]));
        end
      end
      if (done) done_cnt++;
      prev_aw_stall = axi_awvalid && !axi_awready;
      prev_awaddr   = axi_awaddr;
      prev_awlen    = axi_awlen;
      prev_w_stall  = axi_wvalid && !axi_wready;
      prev_wdata    = axi_wdata;
      prev_wlast    = axi_wlast;
    end
  end

  // Stream source and AXI slave, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      pending_b = 0; bwait = 0; aw_wait = 0;
      axi_bvalid = 0; axi_awready = 0; axi_wready = 0;
    end else begin
      if (hs_in) word_ctr = word_ctr + 32'd1;
      in_data  = word_ctr;
      in_valid = (smode == 0) || (cyc % 4 == 0);
      cyc++;
      if (awmode == 0) axi_awready = 1'b1;
      else if (hs_aw) begin axi_awready = 1'b0; aw_wait = 0; end
      else if (axi_awvalid) begin aw_wait++; axi_awready = (aw_wait >= 3); end
      axi_wready = (wmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hs_wlast) pending_b++;
      if (hs_b) begin pending_b--; axi_bvalid = 1'b0; bwait = 0; end
      else if (pending_b > 0 && !axi_bvalid) begin
        if (bwait >= bdelay) axi_bvalid = 1'b1;
        else bwait++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Expected bursts and data for a job whose words start at the current stream word.
  task automatic push_job(input logic [31:0] base, input int total);
    int rem;
    logic [31:0] a;
    rem = total;
    a = base;
    while (rem > 0) begin
      int b;
      b = (rem > BL) ? BL : rem;
      exp_aw_q.push_back({8'(b - 1), a});
      a = a + 32'(b * 4);
      rem -= b;
    end
    for (int i = 0; i < total; i++)
      exp_w_q.push_back({((i % BL) == BL - 1) || (i == total - 1), word_ctr + 32'(i)});
  endtask

  task automatic pulse_start(input logic [31:0] base, input int total);
    start = 1'b1; base_addr = base; total_words = 24'(total);
    step();
    start = 1'b0;
  endtask

  task automatic finish_job(input string name, input int d0, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({name, "_idle"}, 64'(busy), 64'(0));
    repeat (4) step();
    chk({name, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
    chk({name, "_aw_drained"}, 64'(exp_aw_q.size()), 64'(0));
    chk({name, "_w_drained"}, 64'(exp_w_q.size()), 64'(0));
  endtask

  task automatic run_job(input string name, input logic [31:0] base, input int total, input int limit);
    int d0;
    d0 = done_cnt;
    push_job(base, total);
    pulse_start(base, total);
    finish_job(name, d0, limit);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_ctl"}, 64'({busy, done, in_ready, axi_awvalid, axi_wvalid, axi_wlast, axi_bready}), 64'(0));
    chk({name, "_awaddr"}, 64'(axi_awaddr), 64'(0));
    chk({name, "_awlen"}, 64'(axi_awlen), 64'(0));
    chk({name, "_wdata"}, 64'(axi_wdata), 64'(0));
  endtask

  initial begin
    int d0, acc0, w0;
    rstn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk_outputs_zero("reset");
    step();
    rstn = 1'b1;
    repeat (2) step();

    // Two full bursts, ideal slave and stream.
    run_job("t1", 32'h0040_0000, 32, 500);

    // Full burst then a 5-beat tail.
    run_job("t2", 32'h0040_0100, 21, 500);

    // Delayed awready and random wready.
    awmode = 1; wmode = 1;
    run_job("t3", 32'h0040_0200, 40, 2000);
    awmode = 0; wmode = 0;

    // Sparse stream: AW only once a full burst is buffered.
    smode = 1;
    acc0 = acc_cnt; d0 = done_cnt;
    push_job(32'h0040_0400, 16);
    pulse_start(32'h0040_0400, 16);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (axi_awvalid) break;
    end
    chk("t4_aw_gate_acc", 64'(acc_cnt - acc0), 64'(16));
    finish_job("t4a", d0, 500);
    smode = 0;

    // Held-off response: FIFO fills to 64 behind the first burst.
    bdelay = 100;
    acc0 = acc_cnt; d0 = done_cnt;
    push_job(32'h0040_0800, 96);
    pulse_start(32'h0040_0800, 96);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy && !in_ready) break;
    end
    chk("t4_full_stall", 64'(busy && !in_ready), 64'(1));
    chk("t4_full_acc", 64'(acc_cnt - acc0), 64'(80));
    finish_job("t4b", d0, 3000);
    bdelay = 0;

    // Zero-length job: done the cycle after start, no bus activity.
    d0 = done_cnt;
    start = 1'b1; base_addr = 32'h0040_1000; total_words = 24'd0;
    @(negedge clk);
    chk("t5_done_pre", 64'(done), 64'(0));
    step();
    start = 1'b0;
    @(negedge clk);
    chk("t5_done_pulse", 64'({done, busy}), 64'(2'b10));
    @(negedge clk);
    chk("t5_done_end", 64'(done), 64'(0));
    repeat (5) step();
    chk("t5_done_once", 64'(done_cnt), 64'(d0 + 1));

    // Start while busy is ignored.
    d0 = done_cnt;
    push_job(32'h0040_2000, 16);
    pulse_start(32'h0040_2000, 16);
    repeat (3) step();
    start = 1'b1; base_addr = 32'h0040_3000; total_words = 24'd8;
    step();
    start = 1'b0;
    finish_job("t5b", d0, 500);

    // Reset during the second W beat, then a clean job.
    push_job(32'h0040_4000, 32);
    w0 = w_hs_cnt;
    pulse_start(32'h0040_4000, 32);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (axi_wvalid && (w_hs_cnt == w0 + 1)) break;
    end
    chk("t6_second_beat", 64'(axi_wvalid && (w_hs_cnt == w0 + 1)), 64'(1));
    #1 rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    chk_outputs_zero("t6_after_reset");
    exp_aw_q.delete();
    exp_w_q.delete();
    step();
    run_job("t6b", 32'h0040_5000, 16, 500);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
